// File: rtl/am2909_seq.sv
// Am2909-style microprogram address sequencer slice (uPC, R register, return stack).
// Latency: y/cout are combinational from inputs and state; uPC, R, sp and stk_err update on the rising edge of cp.
// Backpressure: none; stack overflow/underflow leaves the stack untouched and sets sticky stk_err.
module am2909_seq #(
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          cp,
  input  logic          reset,
  input  logic [AW-1:0] d,
  input  logic [AW-1:0] r_in,
  input  logic          re,
  input  logic [1:0]    s,
  input  logic          fe,
  input  logic          pup,
  input  logic [AW-1:0] orin,
  input  logic          zero,
  input  logic          cin,
  input  logic          oe,
  output logic [AW-1:0] y,
  output logic          cout,
  output logic          full,
  output logic          empty,
  output logic          stk_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = PW + 1;

  logic [AW-1:0] upc_q, upc_d;
  logic [AW-1:0] r_q, r_d;
  logic [SW-1:0] sp_q, sp_d;
  logic          err_q, err_d;
  logic [AW-1:0] stk_q [DEPTH];

  logic [AW-1:0] mux;
  logic [AW-1:0] y_int;
  logic [AW-1:0] inc;
  logic [AW-1:0] top;
  logic [PW-1:0] top_idx;
  logic          push_ok;
  logic          pop_ok;
  logic          push_bad;
  logic          pop_bad;

  // Stack occupancy flags come straight from the pointer.
  assign full  = (sp_q == SW'(DEPTH));
  assign empty = (sp_q == '0);

  // When full the low pointer bits wrap to 0, so subtracting 1 still lands on the last entry.
  assign top_idx = sp_q[PW-1:0] - PW'(1);
  assign top     = empty ? '0 : stk_q[top_idx];

  assign push_ok  = fe &  pup & ~full;
  assign pop_ok   = fe & ~pup & ~empty;
  assign push_bad = fe &  pup &  full;
  assign pop_bad  = fe & ~pup &  empty;

  // Address source mux: uPC, R, stack top or direct branch address.
  always_comb begin
    mux = upc_q;
    case (s)
      2'b00:   mux = upc_q;
      2'b01:   mux = r_q;
      2'b10:   mux = top;
      default: mux = d;
    endcase
  end

  // Zero-forcing wins over OR-forcing; incrementer carries out only on all-ones plus cin.
  assign y_int       = zero ? '0 : (mux | orin);
  assign {cout, inc} = {1'b0, y_int} + {{AW{1'b0}}, cin};
  assign y           = oe ? y_int : {AW{1'bz}};
  assign stk_err     = err_q;

  // Next-state for uPC, R, stack pointer and the sticky error flag.
  always_comb begin
    upc_d = inc;
    r_d   = r_q;
    sp_d  = sp_q;
    err_d = err_q;
    if (re) begin
      r_d = r_in;
    end
    if (push_ok) begin
      sp_d = sp_q + SW'(1);
    end else if (pop_ok) begin
      sp_d = sp_q - SW'(1);
    end
    if (push_bad || pop_bad) begin
      err_d = 1'b1;
    end
  end

  // Control registers with synchronous reset taking priority over every update.
  always_ff @(posedge cp) begin
    if (reset) begin
      upc_q <= '0;
      r_q   <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage: a push writes the pre-update uPC; pops leave entry contents in place.
  always_ff @(posedge cp) begin
    if (!reset && push_ok) begin
      stk_q[sp_q[PW-1:0]] <= upc_q;
    end
  end

endmodule

// File: tb/tb_am2909_seq.sv
module tb_am2909_seq;

  logic       cp;
  logic       reset;
  logic [3:0] d;
  logic [3:0] r_in;
  logic       re;
  logic [1:0] s;
  logic       fe;
  logic       pup;
  logic [3:0] orin;
  logic       zero;
  logic       cin;
  logic       oe;
  wire  [3:0] y;
  logic       cout;
  logic       full;
  logic       empty;
  logic       stk_err;

  int n_pass;
  int n_total;

  logic [3:0] exp_y_q [$];
  logic       exp_c_q [$];
  logic [3:0] ey;
  logic       ec;

  am2909_seq #(.AW(4), .DEPTH(4)) dut (
    .cp(cp), .reset(reset), .d(d), .r_in(r_in), .re(re), .s(s), .fe(fe),
    .pup(pup), .orin(orin), .zero(zero), .cin(cin), .oe(oe), .y(y),
    .cout(cout), .full(full), .empty(empty), .stk_err(stk_err)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic idle_inputs();
    d = 4'd0; r_in = 4'd0; re = 1'b0; s = 2'b00; fe = 1'b0; pup = 1'b0;
    orin = 4'd0; zero = 1'b0; cin = 1'b0; oe = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_y_q.push_back(4'd0); exp_c_q.push_back(1'b0);
    #1;
    ey = exp_y_q.pop_front(); ec = exp_c_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL reset_y: got %h want %h", y, ey); else n_pass++;
    n_total++; if (cout !== ec) $display("FAIL reset_cout: got %b want %b", cout, ec); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_total++; if (stk_err !== 1'b0) $display("FAIL reset_err: got %b want 0", stk_err); else n_pass++;
  endtask

  task automatic test_continue();
    do_reset();
    cin = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp_y_q.push_back(4'(i % 16));
      exp_c_q.push_back(i == 15);
      #1;
      ey = exp_y_q.pop_front(); ec = exp_c_q.pop_front();
      n_total++; if (y !== ey) $display("FAIL cont_y[%0d]: got %h want %h", i, y, ey); else n_pass++;
      n_total++; if (cout !== ec) $display("FAIL cont_cout[%0d]: got %b want %b", i, cout, ec); else n_pass++;
      tick();
    end
    // 17 increments from 0 wrap through 15 and land on 1; cin=0 now holds it.
    cin = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_y_q.push_back(4'd1);
      #1;
      ey = exp_y_q.pop_front();
      n_total++; if (y !== ey) $display("FAIL hold_y[%0d]: got %h want %h", k, y, ey); else n_pass++;
      tick();
    end
  endtask

  task automatic test_r_load();
    do_reset();
    re = 1'b1; r_in = 4'd9; s = 2'b00; cin = 1'b0;
    exp_y_q.push_back(4'd0);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL rload_a: got %h want %h", y, ey); else n_pass++;
    tick();
    re = 1'b0; s = 2'b01; cin = 1'b1;
    exp_y_q.push_back(4'd9);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL rload_sel: got %h want %h", y, ey); else n_pass++;
    tick();
    s = 2'b00; cin = 1'b0;
    exp_y_q.push_back(4'd10);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL rload_next: got %h want %h", y, ey); else n_pass++;
    tick();
    // Load and select in the same cycle: the old R drives y.
    re = 1'b1; r_in = 4'd6; s = 2'b01;
    exp_y_q.push_back(4'd9);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL rload_old: got %h want %h", y, ey); else n_pass++;
    tick();
    re = 1'b0;
    exp_y_q.push_back(4'd6);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL rload_new: got %h want %h", y, ey); else n_pass++;
    tick();
  endtask

  task automatic test_call_return();
    do_reset();
    cin = 1'b1;
    repeat (3) tick();
    s = 2'b11; d = 4'd12; fe = 1'b1; pup = 1'b1;
    exp_y_q.push_back(4'd12);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL call_y: got %h want %h", y, ey); else n_pass++;
    tick();
    s = 2'b00; fe = 1'b0;
    exp_y_q.push_back(4'd13);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL call_body: got %h want %h", y, ey); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL call_empty: got %b want 0", empty); else n_pass++;
    tick();
    s = 2'b10; fe = 1'b1; pup = 1'b0;
    exp_y_q.push_back(4'd3);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL ret_y: got %h want %h", y, ey); else n_pass++;
    tick();
    s = 2'b00; fe = 1'b0; cin = 1'b0;
    exp_y_q.push_back(4'd4);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL ret_next: got %h want %h", y, ey); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL ret_empty: got %b want 1", empty); else n_pass++;
    // Push while selecting the stack: y shows the old (empty) top, the push of uPC=4 appears next cycle.
    s = 2'b10; fe = 1'b1; pup = 1'b1;
    exp_y_q.push_back(4'd0);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL pushsel_old: got %h want %h", y, ey); else n_pass++;
    tick();
    fe = 1'b0;
    exp_y_q.push_back(4'd4);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL pushsel_new: got %h want %h", y, ey); else n_pass++;
    tick();
  endtask

  task automatic test_stack_limits();
    do_reset();
    cin = 1'b1; fe = 1'b1; pup = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (full !== 1'b0) $display("FAIL fill_full[%0d]: got %b want 0", i, full); else n_pass++;
      tick();
    end
    n_total++; if (full !== 1'b1) $display("FAIL full_set: got %b want 1", full); else n_pass++;
    n_total++; if (stk_err !== 1'b0) $display("FAIL full_err0: got %b want 0", stk_err); else n_pass++;
    tick();
    fe = 1'b0; s = 2'b10; cin = 1'b0;
    exp_y_q.push_back(4'd3);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (stk_err !== 1'b1) $display("FAIL ovf_err: got %b want 1", stk_err); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL ovf_full: got %b want 1", full); else n_pass++;
    n_total++; if (y !== ey) $display("FAIL ovf_top: got %h want %h", y, ey); else n_pass++;
    // A legal pop afterwards does not clear the sticky flag.
    fe = 1'b1; pup = 1'b0;
    tick();
    fe = 1'b0;
    exp_y_q.push_back(4'd2);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (stk_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", stk_err); else n_pass++;
    n_total++; if (y !== ey) $display("FAIL pop_top: got %h want %h", y, ey); else n_pass++;
    do_reset();
    s = 2'b10; fe = 1'b1; pup = 1'b0;
    exp_y_q.push_back(4'd0);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL udf_y: got %h want %h", y, ey); else n_pass++;
    tick();
    fe = 1'b0;
    #1;
    n_total++; if (stk_err !== 1'b1) $display("FAIL udf_err: got %b want 1", stk_err); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL udf_empty: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_forcing();
    do_reset();
    s = 2'b11; d = 4'b0100; orin = 4'b0011;
    exp_y_q.push_back(4'd7); exp_c_q.push_back(1'b0);
    #1; ey = exp_y_q.pop_front(); ec = exp_c_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL or_y: got %h want %h", y, ey); else n_pass++;
    n_total++; if (cout !== ec) $display("FAIL or_cout: got %b want %b", cout, ec); else n_pass++;
    zero = 1'b1;
    exp_y_q.push_back(4'd0);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL zero_y: got %h want %h", y, ey); else n_pass++;
    zero = 1'b0; d = 4'd0; orin = 4'hf; cin = 1'b1;
    exp_y_q.push_back(4'hf); exp_c_q.push_back(1'b1);
    #1; ey = exp_y_q.pop_front(); ec = exp_c_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL allone_y: got %h want %h", y, ey); else n_pass++;
    n_total++; if (cout !== ec) $display("FAIL allone_cout: got %b want %b", cout, ec); else n_pass++;
    do_reset();
    cin = 1'b1;
    repeat (2) tick();
    // Bus released: y must not carry the internal address 2,3,4 while uPC keeps counting.
    oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_y_q.push_back(4'(2 + i));
      #1; ey = exp_y_q.pop_front();
      n_total++; if (y === ey) $display("FAIL oe_off[%0d]: got %h want released", i, y); else n_pass++;
      tick();
    end
    oe = 1'b1; cin = 1'b0;
    exp_y_q.push_back(4'd5);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL oe_back: got %h want %h", y, ey); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    re = 1'b1; r_in = 4'd5; cin = 1'b1; fe = 1'b1; pup = 1'b1;
    repeat (2) tick();
    re = 1'b0; fe = 1'b0; s = 2'b11; d = 4'd7;
    tick();
    s = 2'b00; cin = 1'b0;
    exp_y_q.push_back(4'd8);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL mid_pre_y: got %h want %h", y, ey); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL mid_pre_empty: got %b want 0", empty); else n_pass++;
    // Reset must win over simultaneous R load, push and increment.
    reset = 1'b1; re = 1'b1; r_in = 4'hf; fe = 1'b1; pup = 1'b1; cin = 1'b1;
    tick();
    reset = 1'b0; re = 1'b0; fe = 1'b0; cin = 1'b0; s = 2'b00;
    exp_y_q.push_back(4'd0);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL mid_upc: got %h want %h", y, ey); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL mid_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL mid_full: got %b want 0", full); else n_pass++;
    n_total++; if (stk_err !== 1'b0) $display("FAIL mid_err: got %b want 0", stk_err); else n_pass++;
    s = 2'b01;
    exp_y_q.push_back(4'd0);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL mid_r: got %h want %h", y, ey); else n_pass++;
    s = 2'b10;
    exp_y_q.push_back(4'd0);
    #1; ey = exp_y_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL mid_top: got %h want %h", y, ey); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    idle_inputs();
    reset = 1'b1;
    tick();
    test_reset();
    test_continue();
    test_r_load();
    test_call_return();
    test_stack_limits();
    test_forcing();
    test_reset_mid();
    n_total++; if (exp_y_q.size() != 0 || exp_c_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", exp_y_q.size(), exp_c_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/am2909_seq.md
Name: am2909_seq

Overview:
- Microprogram address sequencer that sits directly upstream of the Am2901 slice.
- It generates the microinstruction address each cycle. The microcode ROM read at that address supplies the Am2901's i[8:0], a, b, d and cin.
- It contains a source mux (uPC / R register / stack top / direct), OR-forcing and zero-forcing of the address, an incrementer with carry out, an R register, and a push/pop return stack.
- It is a 4-bit slice like the Am2901. Carry chaining through cin/cout allows wider addresses.

Parameters:
AW, 4, address width in bits.
DEPTH, 4, return stack depth in entries. Must be a power of two, 2 or more.

Ports:
cp  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
d  input  AW  direct branch address.
r_in  input  AW  data input to the R register.
re  input  1  R register load enable.
s  input  2  source select: 00 uPC, 01 R, 10 stack top, 11 d.
fe  input  1  stack operation enable.
pup  input  1  stack direction when fe=1: 1 push, 0 pop.
orin  input  AW  bitwise OR mask applied to the selected address.
zero  input  1  forces the internal address to 0.
cin  input  1  incrementer carry in.
oe  input  1  output enable for y.
y  output  AW  next microinstruction address (tristate).
cout  output  1  incrementer carry out.
full  output  1  stack holds DEPTH entries.
empty  output  1  stack holds 0 entries.
stk_err  output  1  sticky flag: push while full, or pop while empty.

Behaviour:
- Combinational address path, no latency from inputs to y:
  - mux = uPC, R, top or d according to s.
  - y_int = zero ? 0 : (mux | orin).
  - y = oe ? y_int : high-Z.
- Incrementer: {cout, inc} = y_int + cin, computed in AW+1 bits.
  - cout is combinational and is 1 only when y_int is all ones and cin=1.
  - inc wraps modulo 2^AW.
- Stack top:
  - top = stack[sp-1] when sp>0.
  - top reads 0 when empty.
- Rising edge of cp, reset=0:
  - uPC <= inc.
  - If re=1: R <= r_in.
  - If fe=1 and pup=1 and not full: stack[sp] <= current uPC (the pre-update value), sp <= sp+1.
  - If fe=1 and pup=0 and not empty: sp <= sp-1. Entry contents are not cleared.
  - Push while full: stack and sp unchanged, stk_err <= 1.
  - Pop while empty: sp unchanged, stk_err <= 1.
  - fe=0: stack unchanged; pup is ignored.
- Simultaneous events in one cycle:
  - s=10 together with a pop: y uses the top before the pop. This is the return operation.
  - s=10 together with a push: y uses the old top. The pushed value becomes visible next cycle.
  - re=1 together with s=01: y uses the old R. The new R is visible next cycle.
- Status flags:
  - full = (sp==DEPTH) and empty = (sp==0). Both are combinational from sp.
  - sp is AW-independent and has log2(DEPTH)+1 bits.
  - stk_err stays set until reset.
- Reset (synchronous, any cycle including mid-sequence):
  - uPC <= 0, R <= 0, sp <= 0, stk_err <= 0. Stack entries are don't-care.
  - After reset: empty=1, full=0, stk_err=0.
  - With s=00, orin=0, zero=0, cin=0: y=0 and cout=0.
  - reset takes priority over re, fe and the uPC update.
- Continue: s=00 with cin=1 advances the address by 1 every cycle.
- Hold: s=00 with cin=0 holds the current address.

Test Plan:
- Reset, then s=00, cin=1, oe=1 for 17 cycles → y steps 0,1,…,15,0.
  - cout=1 exactly in the cycle where y=15.
- Load R=9 with re=1, next cycle s=01, cin=1 → y=9; the following cycle s=00 → y=10.
- Subroutine call and return:
  - At uPC=3: s=11, d=12, fe=1, pup=1, cin=1 → y=12; the stack now holds 3.
  - Later: s=10, fe=1, pup=0, cin=1 → y=3, empty=1, next uPC=4.
- Stack limits:
  - Push 4 times → full=1. A 5th push → stk_err=1, sp stays 4, top unchanged.
  - Reset, then pop → stk_err=1, empty=1, y=0 when s=10.
- Forcing inputs:
  - s=11, d=4'b0100, orin=4'b0011 → y=7.
  - Set zero=1 → y=0.
  - oe=0 → y is high-Z while uPC still advances.
- Reset mid-operation: sp=2, R=5, uPC=8, assert reset for 1 cycle → sp=0, R=0, uPC=0, stk_err=0.
